// File: rtl/noc_mux2.sv
// 2-to-1 flit mux with one-hot select on sel[1:0]; outputs registered, 1-cycle latency.
// No backpressure or buffering: the selected stream is forwarded every cycle unconditionally.
module noc_mux2 #(
  parameter int DATA_W = 64,
  parameter int VCH_W  = 2,
  parameter int SEL_W  = 5
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic [DATA_W-1:0] idata_0,
  input  logic              ivalid_0,
  input  logic [VCH_W-1:0]  ivch_0,
  input  logic [DATA_W-1:0] idata_1,
  input  logic              ivalid_1,
  input  logic [VCH_W-1:0]  ivch_1,
  input  logic [SEL_W-1:0]  sel,
  output logic [DATA_W-1:0] odata,
  output logic              ovalid,
  output logic [VCH_W-1:0]  ovch,
  output logic              oerr
);

  logic [DATA_W-1:0] data_d, data_q;
  logic              valid_d, valid_q;
  logic [VCH_W-1:0]  vch_d, vch_q;
  logic              err_d, err_q;

  // Only the two low select bits belong to this leaf; the rest address other router ports.
  generate
    if (SEL_W > 2) begin : g_sel_hi
      logic unused_sel_hi;
      assign unused_sel_hi = ^sel[SEL_W-1:2];
    end
  endgenerate

  always_comb begin
    data_d  = '0;
    valid_d = 1'b0;
    vch_d   = '0;
    err_d   = 1'b0;
    case (sel[1:0])
      2'b01: begin
        data_d  = idata_0;
        valid_d = ivalid_0;
        vch_d   = ivch_0;
      end
      2'b10: begin
        data_d  = idata_1;
        valid_d = ivalid_1;
        vch_d   = ivch_1;
      end
      // Both bits set: port 0 wins so the datapath stays deterministic, and the error is flagged.
      2'b11: begin
        data_d  = idata_0;
        valid_d = ivalid_0;
        vch_d   = ivch_0;
        err_d   = 1'b1;
      end
      default: begin
        data_d  = '0;
        valid_d = 1'b0;
        vch_d   = '0;
        err_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      vch_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      vch_q   <= vch_d;
      err_q   <= err_d;
    end
  end

  assign odata  = data_q;
  assign ovalid = valid_q;
  assign ovch   = vch_q;
  assign oerr   = err_q;

endmodule

// File: tb/tb_noc_mux2.sv
// Directed bench for noc_mux2: reset, both ports, idle, illegal select, bit-toggle patterns.
module tb_noc_mux2;
  localparam int DATA_W = 64;
  localparam int VCH_W  = 2;
  localparam int SEL_W  = 5;

  logic              clk = 1'b0;
  logic              rst_;
  logic [DATA_W-1:0] idata_0, idata_1;
  logic              ivalid_0, ivalid_1;
  logic [VCH_W-1:0]  ivch_0, ivch_1;
  logic [SEL_W-1:0]  sel;
  logic [DATA_W-1:0] odata;
  logic              ovalid;
  logic [VCH_W-1:0]  ovch;
  logic              oerr;

  int tests = 0;
  int fails = 0;

  noc_mux2 #(.DATA_W(DATA_W), .VCH_W(VCH_W), .SEL_W(SEL_W)) dut (
    .clk(clk), .rst_(rst_),
    .idata_0(idata_0), .ivalid_0(ivalid_0), .ivch_0(ivch_0),
    .idata_1(idata_1), .ivalid_1(ivalid_1), .ivch_1(ivch_1),
    .sel(sel),
    .odata(odata), .ovalid(ovalid), .ovch(ovch), .oerr(oerr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [DATA_W-1:0] d, input logic v,
                           input logic [VCH_W-1:0] c, input logic e);
    check({tag, ".odata"}, odata, d);
    check({tag, ".ovalid"}, {63'd0, ovalid}, {63'd0, v});
    check({tag, ".ovch"}, {62'd0, ovch}, {62'd0, c});
    check({tag, ".oerr"}, {63'd0, oerr}, {63'd0, e});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [DATA_W-1:0] flit;
  logic [DATA_W-1:0] pats [6];

  initial begin
    // Reset held with every input nonzero
    rst_ = 1'b0;
    idata_0 = 64'hDEAD_BEEF_0000_0001; ivalid_0 = 1'b1; ivch_0 = 2'd3;
    idata_1 = 64'hCAFE_F00D_0000_0002; ivalid_1 = 1'b1; ivch_1 = 2'd1;
    sel = 5'b00011;
    tick(); tick();
    check_all("reset_hold", '0, 1'b0, 2'd0, 1'b0);

    // Deassert; outputs keep reset values until the next edge
    rst_ = 1'b1;
    sel = 5'b00001;
    idata_0 = 64'h1234_5678_9ABC_DEF0; ivalid_0 = 1'b1; ivch_0 = 2'd2;
    #1;
    check_all("post_reset_hold", '0, 1'b0, 2'd0, 1'b0);
    tick();
    check_all("port0", 64'h1234_5678_9ABC_DEF0, 1'b1, 2'd2, 1'b0);

    // Async reset between edges clears immediately
    #2;
    rst_ = 1'b0;
    #1;
    check_all("async_reset", '0, 1'b0, 2'd0, 1'b0);
    rst_ = 1'b1;
    tick();
    check_all("first_edge_after_reset", 64'h1234_5678_9ABC_DEF0, 1'b1, 2'd2, 1'b0);

    // Port 1 packet: head(0x04), 20 bodies, tail; port 0 carries distractors
    sel = 5'b00010;
    ivalid_1 = 1'b1; ivch_1 = 2'd1;
    for (int k = 0; k < 22; k++) begin
      if (k == 0)       flit = {2'b01, 62'h04};
      else if (k == 21) flit = {2'b10, 62'h7E00 + 62'(k)};
      else              flit = {2'b00, 62'h1000 + 62'(k * 17)};
      idata_1 = flit;
      idata_0 = (k == 0) ? {2'b01, 62'h09} : {$urandom, $urandom};
      ivalid_0 = k[0];
      ivch_0 = 2'(k);
      tick();
      check_all($sformatf("pkt1_flit%0d", k), flit, 1'b1, 2'd1, 1'b0);
    end

    // Idle select with both ports valid
    sel = 5'b00000;
    ivalid_0 = 1'b1; ivalid_1 = 1'b1; ivch_0 = 2'd3; ivch_1 = 2'd2;
    tick();
    check_all("idle", '0, 1'b0, 2'd0, 1'b0);

    // Data passes through with valid low
    sel = 5'b00010;
    ivalid_1 = 1'b0; idata_1 = 64'hFF; ivch_1 = 2'd3;
    tick();
    check_all("valid0_passthru", 64'hFF, 1'b0, 2'd3, 1'b0);

    // Illegal select: port 0 wins, error flagged
    idata_0 = 64'hA5A5_A5A5_A5A5_A5A5; ivalid_0 = 1'b1; ivch_0 = 2'd3;
    idata_1 = 64'h5A5A_5A5A_5A5A_5A5A; ivalid_1 = 1'b0; ivch_1 = 2'd1;
    sel = 5'b00011;
    tick();
    check_all("illegal_sel", 64'hA5A5_A5A5_A5A5_A5A5, 1'b1, 2'd3, 1'b1);

    // Upper select bits ignored
    sel = 5'b10010;
    tick();
    check_all("upper_sel_ignored", 64'h5A5A_5A5A_5A5A_5A5A, 1'b0, 2'd1, 1'b0);

    // Bit-toggle patterns on port 1
    pats[0] = 64'h0;
    pats[1] = 64'hFFFF_FFFF_FF00;
    pats[2] = 64'h0000_0000_FFFF;
    pats[3] = 64'hFFFF_FFFF_FFFF_FFFF;
    pats[4] = 64'h0;
    pats[5] = 64'hAAAA_5555_00FF_FF00;
    sel = 5'b00010; ivalid_1 = 1'b1; ivch_1 = 2'd2;
    for (int k = 0; k < 6; k++) begin
      idata_1 = pats[k];
      tick();
      check($sformatf("toggle%0d.odata", k), odata, pats[k]);
      check($sformatf("toggle%0d.noX", k), {63'd0, $isunknown({odata, ovalid, ovch, oerr})}, 64'd0);
    end

    // Constant inputs give constant outputs
    for (int k = 0; k < 3; k++) begin
      tick();
      check_all($sformatf("steady%0d", k), 64'hAAAA_5555_00FF_FF00, 1'b1, 2'd2, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/noc_mux2.md
Name: noc_mux2

Overview:
- 2-to-1 flit multiplexer for the NoC router output stage.
- Selects one of two input flit streams (data, valid, virtual-channel ID) with a one-hot select vector and drives a single registered output port.
- Used standalone for per-bit-width switching-energy characterization and as the crossbar leaf inside the router.

Parameters:
- DATA_W, 64, flit width in bits; includes the type field in the top bits.
- VCH_W, 2, virtual-channel ID width.
- SEL_W, 5, select vector width (router port count); only bits [1:0] are decoded.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_  in  1  asynchronous, active-low reset.
- idata_0  in  DATA_W  port 0 flit.
- ivalid_0  in  1  port 0 flit valid.
- ivch_0  in  VCH_W  port 0 virtual channel.
- idata_1  in  DATA_W  port 1 flit.
- ivalid_1  in  1  port 1 flit valid.
- ivch_1  in  VCH_W  port 1 virtual channel.
- sel  in  SEL_W  one-hot select: bit0 selects port 0, bit1 selects port 1.
- odata  out  DATA_W  selected flit, registered.
- ovalid  out  1  selected valid, registered.
- ovch  out  VCH_W  selected VC, registered.
- oerr  out  1  registered illegal-select flag.

Behaviour:
- Reset: rst_=0 asynchronously forces odata=0, ovalid=0, ovch=0, oerr=0, independent of clk.
- Outputs hold reset values until the first rising edge after rst_ deasserts.
- Latency: exactly 1 cycle. Inputs and sel sampled at rising edge N appear on the outputs after edge N.
- Select decode on sel[1:0]:
  - 01: output takes {idata_0, ivalid_0, ivch_0}.
  - 10: output takes {idata_1, ivalid_1, ivch_1}.
  - 00: idle. odata=0, ovalid=0, ovch=0.
  - 11: illegal. Port 0 wins; oerr=1 for that cycle.
- oerr is 0 for every legal select value.
- sel[SEL_W-1:2] are ignored and have no effect.
- Data and VC pass through unconditionally for the selected port, even when its valid is 0. ovalid mirrors the selected ivalid. No flit-type decoding, no buffering, no backpressure.
- The unselected port has no effect on any output.
- A sel change takes effect on the next edge. No flit is held over, so a switch mid-packet is the upstream arbiter's responsibility.
- Every output updates every cycle. With constant inputs, outputs are constant (no spurious toggling).
- Reset asserted mid-stream clears the outputs immediately. The first post-reset edge samples the current inputs normally.

Test Plan:
- Reset: hold rst_=0 with all inputs driven to nonzero values → odata=0, ovalid=0, ovch=0, oerr=0. Assert rst_ between edges → outputs clear without waiting for a clock edge.
- Port 1 select: sel=5'b00010, idata_1 = head flit with payload 0x04, ivalid_1=1, ivch_1=1, then 20 data flits and a tail → odata follows idata_1 one cycle later, flit for flit; ovalid=1; ovch=1. idata_0 activity (payload 0x09 and random flits) never appears on the outputs.
- Port 0 select: sel=5'b00001, idata_0=0x1234_5678_9ABC_DEF0, ivalid_0=1, ivch_0=2 → after 1 edge odata=0x1234_5678_9ABC_DEF0, ovalid=1, ovch=2, oerr=0.
- Idle and valid passthrough: sel=0 with both ports valid → odata=0, ovalid=0, ovch=0. Then sel=5'b00010 with ivalid_1=0 and idata_1=0xFF → odata=0xFF, ovalid=0.
- Illegal select: sel=5'b00011 → outputs equal port 0 and oerr=1. Next cycle sel=5'b10010 → outputs equal port 1 (upper bits ignored) and oerr=0.
- Bit-toggle patterns on port 1: cycle the rotating all-0 / all-1 / partial-byte patterns (e.g. 0, 0xFFFFFFFFFF00, 0x00000000FFFF, all-ones) → odata reproduces each pattern exactly one cycle later, with no X on any output bit.
